// File: rtl/stack_ctrl_unit.sv
// Multi-cycle fetch/decode/execute controller for the 8-opcode stack ISA.
// Owns pc, sp and the tmp/b operand registers; sequences ROM, data RAM and stack memory.
module stack_ctrl_unit #(
    parameter int INST_W      = 16,
    parameter int DATA_W      = 8,
    parameter int ROM_AW      = 5,
    parameter int RAM_AW      = 5,
    parameter int STACK_DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [INST_W-1:0]              inst_i,
    input  logic [DATA_W-1:0]              data_mem_i,
    input  logic [DATA_W-1:0]              stk_rdata_i,
    output logic [ROM_AW-1:0]              a_rom_o,
    output logic                           rom_en_o,
    output logic [RAM_AW-1:0]              a_ram_o,
    output logic                           ram_en_o,
    output logic                           ram_wren_o,
    output logic [DATA_W-1:0]              ram_wdata_o,
    output logic [$clog2(STACK_DEPTH)-1:0] stk_addr_o,
    output logic                           stk_wren_o,
    output logic [DATA_W-1:0]              stk_wdata_o,
    output logic [ROM_AW-1:0]              pc_o,
    output logic [$clog2(STACK_DEPTH):0]   sp_o,
    output logic [3:0]                     opcode_o,
    output logic                           halted_o,
    output logic                           error_o,
    output logic [1:0]                     err_code_o
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ZERO = SP_W'(0);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_TWO  = SP_W'(2);

    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_PUSHI = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_JZ    = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_UNF = 2'd2;
    localparam logic [1:0] ERR_ILL = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_RD  = 4'd3,
        S_LOAD    = 4'd4,
        S_STK_RD  = 4'd5,
        S_STK_RD2 = 4'd6,
        S_EXEC    = 4'd7,
        S_STK_WR  = 4'd8,
        S_MEM_WR  = 4'd9,
        S_JZ_EVAL = 4'd10,
        S_HALT    = 4'd11,
        S_ERROR   = 4'd12
    } state_t;

    state_t              state_q, state_d;
    logic [ROM_AW-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   tmp_q, tmp_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [3:0]          dec_op_s;
    logic [ROM_AW-1:0]   dec_t_s;
    logic [DATA_W-1:0]   dec_imm_s;
    logic                dec_ill_s;
    logic                dec_ovf_s;
    logic                dec_unf_s;
    logic [3:0]          ir_op_s;
    logic [RAM_AW-1:0]   ir_a_s;
    logic [ROM_AW-1:0]   ir_t_s;
    logic [SP_W-1:0]     sp_m1_s;
    logic                unused_bits_s;

    // DECODE works on the ROM word as it arrives; later states use the latched ir
    assign dec_op_s  = inst_i[INST_W-1 -: 4];
    assign dec_t_s   = inst_i[ROM_AW-1:0];
    assign dec_imm_s = inst_i[DATA_W-1:0];
    assign dec_ill_s = dec_op_s[3];
    assign dec_ovf_s = ((dec_op_s == OP_PUSH) || (dec_op_s == OP_PUSHI)) && (sp_q == SP_FULL);
    assign dec_unf_s = (((dec_op_s == OP_POP) || (dec_op_s == OP_JZ)) && (sp_q == SP_ZERO)) ||
                       (((dec_op_s == OP_ADD) || (dec_op_s == OP_SUB)) && (sp_q < SP_TWO));

    assign ir_op_s       = ir_q[INST_W-1 -: 4];
    assign ir_a_s        = ir_q[RAM_AW-1:0];
    assign ir_t_s        = ir_q[ROM_AW-1:0];
    assign sp_m1_s       = sp_q - SP_ONE;
    assign unused_bits_s = ^{ir_q, sp_m1_s[SP_W-1]};

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            sp_q       <= '0;
            ir_q       <= '0;
            tmp_q      <= '0;
            b_q        <= '0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            ir_q       <= ir_d;
            tmp_q      <= tmp_d;
            b_q        <= b_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        ir_d       = ir_q;
        tmp_d      = tmp_q;
        b_d        = b_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = inst_i;
                if (dec_op_s == OP_JMP) begin
                    pc_d = dec_t_s;
                end else begin
                    pc_d = pc_q + ROM_AW'(1);
                end
                if (dec_ill_s) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_ILL;
                end else if (dec_ovf_s) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_OVF;
                end else if (dec_unf_s) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_UNF;
                end else begin
                    case (dec_op_s)
                        OP_PUSH:  state_d = S_MEM_RD;
                        OP_PUSHI: begin
                            tmp_d   = dec_imm_s;
                            state_d = S_STK_WR;
                        end
                        OP_POP, OP_ADD, OP_SUB, OP_JZ: state_d = S_STK_RD;
                        OP_JMP:   state_d = S_FETCH;
                        OP_HALT:  state_d = S_HALT;
                        default:  state_d = S_ERROR;
                    endcase
                end
            end
            S_MEM_RD: state_d = S_LOAD;
            S_LOAD: begin
                tmp_d   = data_mem_i;
                state_d = S_STK_WR;
            end
            S_STK_RD: begin
                sp_d = sp_m1_s;
                case (ir_op_s)
                    OP_POP:         state_d = S_MEM_WR;
                    OP_ADD, OP_SUB: state_d = S_STK_RD2;
                    OP_JZ:          state_d = S_JZ_EVAL;
                    default:        state_d = S_ERROR;
                endcase
            end
            S_STK_RD2: begin
                b_d     = stk_rdata_i;
                sp_d    = sp_m1_s;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // second operand (deeper entry) minus/plus TOS; carry is dropped by the width
                if (ir_op_s == OP_ADD) begin
                    tmp_d = stk_rdata_i + b_q;
                end else begin
                    tmp_d = stk_rdata_i - b_q;
                end
                state_d = S_STK_WR;
            end
            S_STK_WR: begin
                sp_d    = sp_q + SP_ONE;
                state_d = S_FETCH;
            end
            S_MEM_WR: state_d = S_FETCH;
            S_JZ_EVAL: begin
                if (stk_rdata_i == DATA_W'(0)) begin
                    pc_d = ir_t_s;
                end else begin
                    pc_d = pc_q;
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and addresses decoded from registered state only
    always_comb begin
        a_rom_o     = '0;
        rom_en_o    = 1'b0;
        a_ram_o     = '0;
        ram_en_o    = 1'b0;
        ram_wren_o  = 1'b0;
        ram_wdata_o = '0;
        stk_addr_o  = '0;
        stk_wren_o  = 1'b0;
        halted_o    = 1'b0;
        error_o     = 1'b0;
        case (state_q)
            S_FETCH: begin
                rom_en_o = 1'b1;
                a_rom_o  = pc_q;
            end
            S_MEM_RD: begin
                ram_en_o = 1'b1;
                a_ram_o  = ir_a_s;
            end
            S_STK_RD, S_STK_RD2: stk_addr_o = sp_m1_s[SP_W-2:0];
            S_STK_WR: begin
                stk_wren_o = 1'b1;
                stk_addr_o = sp_q[SP_W-2:0];
            end
            S_MEM_WR: begin
                ram_wren_o  = 1'b1;
                a_ram_o     = ir_a_s;
                ram_wdata_o = stk_rdata_i;
            end
            S_HALT:  halted_o = 1'b1;
            S_ERROR: error_o  = 1'b1;
            default: a_rom_o  = '0;
        endcase
    end

    assign stk_wdata_o = tmp_q;
    assign pc_o        = pc_q;
    assign sp_o        = sp_q;
    assign opcode_o    = ir_op_s;
    assign err_code_o  = err_code_q;

endmodule

// File: doc/stack_ctrl_unit.md
# stack_ctrl_unit

Parametrised multi-cycle control unit for the stack processor. Fetches instructions from the synchronous instruction ROM, decodes an 8-opcode stack ISA, and sequences the data RAM and an external stack memory. It owns the program counter, stack pointer and a result register, and flags halt and error conditions. It adds arithmetic, branching, immediate push, pop and overflow/underflow detection over the previous single-opcode push-only controller.

## Interface
- INST_W, 16, instruction width; must be ≥ 4 + max(ROM_AW, RAM_AW, DATA_W)
- DATA_W, 8, data/stack word width
- ROM_AW, 5, instruction ROM address width
- RAM_AW, 5, data RAM address width
- STACK_DEPTH, 16, stack entries (power of two); SP_W = clog2(STACK_DEPTH)+1
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; forces state IDLE and all registers to reset values
- start  in  1  leave IDLE when high (sampled in IDLE only)
- inst  in  INST_W  ROM read data, valid one cycle after a_rom/rom_en
- data_mem  in  DATA_W  RAM read data, valid one cycle after a_ram/ram_en
- stk_rdata  in  DATA_W  stack read data, valid one cycle after stk_addr
- a_rom  out  ROM_AW  ROM address (= pc in FETCH, else 0)
- rom_en  out  1  ROM read strobe
- a_ram  out  RAM_AW  RAM address
- ram_en  out  1  RAM read strobe
- ram_wren  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- stk_addr  out  SP_W-1  stack address
- stk_wren  out  1  stack write enable
- stk_wdata  out  DATA_W  stack write data (= tmp)
- pc  out  ROM_AW  program counter
- sp  out  SP_W  stack pointer (entries in use)
- opcode  out  4  latched opcode ir[INST_W-1:INST_W-4]
- halted  out  1  high in HALT
- error  out  1  high in ERROR
- err_code  out  2  1 overflow, 2 underflow, 3 illegal opcode

## Operation
- Opcodes: 0 PUSH a (RAM[a]→stack), 1 POP a (stack→RAM[a]), 2 PUSHI imm, 3 ADD, 4 SUB, 5 JMP t, 6 JZ t (pop; jump if zero), 7 HALT, 8–15 illegal.
- Operand fields: a = ir[RAM_AW-1:0], t = ir[ROM_AW-1:0], imm = ir[DATA_W-1:0].
- States: IDLE, FETCH, DECODE, MEM_RD, LOAD, STK_RD, STK_RD2, EXEC, STK_WR, MEM_WR, JZ_EVAL, HALT, ERROR.
- IDLE: start → FETCH.
- FETCH: rom_en=1, a_rom=pc → DECODE.
- DECODE: ir←inst; pc←pc+1 mod 2^ROM_AW (JMP: pc←t instead). Checks, in priority: illegal → ERROR(3); PUSH/PUSHI with sp==STACK_DEPTH → ERROR(1); POP/JZ with sp==0, ADD/SUB with sp<2 → ERROR(2). Otherwise: PUSH→MEM_RD; PUSHI tmp←imm →STK_WR; POP/ADD/SUB/JZ→STK_RD; JMP→FETCH; HALT→HALT.
- MEM_RD: ram_en=1, a_ram=a → LOAD. LOAD: tmp←data_mem → STK_WR.
- STK_RD: stk_addr=sp-1, sp←sp-1 → POP: MEM_WR; ADD/SUB: STK_RD2; JZ: JZ_EVAL.
- STK_RD2: b←stk_rdata (TOS); stk_addr=sp-1, sp←sp-1 → EXEC.
- EXEC: tmp←stk_rdata + b (ADD) or stk_rdata − b (SUB), mod 2^DATA_W, carry/borrow discarded → STK_WR.
- STK_WR: stk_wren=1, stk_addr=sp, sp←sp+1 → FETCH.
- MEM_WR: ram_wren=1, a_ram=a, ram_wdata=stk_rdata → FETCH.
- JZ_EVAL: if stk_rdata==0, pc←t → FETCH.
- HALT, ERROR: terminal; only reset exits. Strobes low.
- Strobes (rom_en, ram_en, ram_wren, stk_wren) high only in the states named above.

## Timing
- Reset values: all outputs 0, pc=0, sp=0, tmp=b=ir=0, state IDLE. Assertion mid-instruction aborts with no further strobes; any write already clocked stands.
- Cycles per instruction, FETCH included: JMP 2, PUSHI 3, HALT 2, POP 4, JZ 4, PUSH 5, ADD/SUB 6; error detection 2.
- First FETCH is the cycle after start is sampled high.
- pc wraps from 2^ROM_AW−1 to 0. sp range is 0..STACK_DEPTH; PUSH at sp==STACK_DEPTH−1 is legal and reaches full.
- All memories are synchronous-read with 1-cycle latency. No combinational path from any input to any strobe.

## Test plan
- PUSHI 5, PUSHI 3, SUB, POP 2, HALT → RAM[2]=2, sp=0, halted=1; SUB takes 6 cycles.
- RAM[4]=0xFF; PUSH 4, PUSHI 1, ADD, POP 4 → RAM[4]=0x00, no error.
- 16 PUSHI then 17th PUSHI → sp=16, error=1, err_code=1, no 17th stk_wren.
- POP 0 on empty stack → error=1, err_code=2; ADD with sp=1 → err_code=2.
- PUSHI 0, JZ 9 → pc=9; PUSHI 1, JZ 9 → pc continues sequentially; JMP 31 then next FETCH at 31, following at 0.
- Opcode 12 → err_code=3; reset asserted during LOAD → next cycle state IDLE, all outputs 0.
